// File: rtl/lut_pkg.sv
// Shared definitions for the programmable LUT function unit: loader states,
// table sizing and the default prime-minterm table.
package lut_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    // Truth-table width for an n-input function (one bit per minterm).
    function automatic int table_width(input int n_in);
        return 1 << n_in;
    endfunction

    // Minterms 2,3,5,7,11,13 of a 4-input function.
    localparam logic [15:0] DEFAULT_TABLE_4 = 16'h28AC;

endpackage

// File: rtl/lut_cfg_loader.sv
// Serial truth-table loader: collects TABLE_W bits MSB-first into a shadow
// register and strobes commit once a complete table has been received.
module lut_cfg_loader
    import lut_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int TABLE_W = table_width(N_IN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_start,
    input  logic               cfg_bit_valid,
    input  logic               cfg_bit,
    output logic [TABLE_W-1:0] shadow_table,
    output logic               commit,
    output logic               cfg_busy,
    output logic               cfg_done
);

    // One extra bit so the count reaches TABLE_W without wrapping.
    localparam int CNT_W = N_IN + 1;

    cfg_state_t         state_reg;
    logic [TABLE_W-1:0] shadow_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               busy_reg;
    logic               done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            shadow_reg <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cfg_start) begin
                        state_reg  <= LOAD;
                        busy_reg   <= 1'b1;
                        count_reg  <= '0;
                        shadow_reg <= '0;
                    end
                end
                LOAD: begin
                    // A restart takes priority; any bit offered alongside it is dropped.
                    if (cfg_start) begin
                        count_reg  <= '0;
                        shadow_reg <= '0;
                    end else if (cfg_bit_valid) begin
                        shadow_reg <= {shadow_reg[TABLE_W-2:0], cfg_bit};
                        count_reg  <= count_reg + 1'b1;
                        if (count_reg == CNT_W'(TABLE_W - 1)) begin
                            state_reg <= COMMIT;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign shadow_table = shadow_reg;
    assign commit       = done_reg;
    assign cfg_busy     = busy_reg;
    assign cfg_done     = done_reg;

endmodule

// File: rtl/lut_function_unit.sv
// Run-time programmable N-input Boolean function: registered table lookup
// with an atomically swapped truth table fed by the serial loader.
module lut_function_unit
    import lut_pkg::*;
#(
    parameter int                            N_IN       = 4,
    parameter logic [table_width(N_IN)-1:0]  INIT_TABLE = DEFAULT_TABLE_4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_vec,
    output logic            f,
    output logic            out_valid,
    input  logic            cfg_start,
    input  logic            cfg_bit_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done
);

    localparam int TABLE_W = table_width(N_IN);

    logic [TABLE_W-1:0] shadow_table;
    logic               commit;
    logic [TABLE_W-1:0] table_reg;
    logic               f_reg;
    logic               out_valid_reg;

    lut_cfg_loader #(
        .N_IN    (N_IN),
        .TABLE_W (TABLE_W)
    ) u_loader (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_bit_valid (cfg_bit_valid),
        .cfg_bit       (cfg_bit),
        .shadow_table  (shadow_table),
        .commit        (commit),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done)
    );

    // The lookup below reads table_reg before this edge's update, so a
    // request in the commit cycle still sees the old function.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_reg <= INIT_TABLE;
        end else if (commit) begin
            table_reg <= shadow_table;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_reg         <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                f_reg <= table_reg[in_vec];
            end
        end
    end

    assign f         = f_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_lut_function_unit.sv
// Directed and randomized checks of two lut_function_unit instances
// (4-input default table and 2-input XOR table) against a behavioural model.
module tb_lut_function_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_vec4;
    logic [1:0] in_vec2;
    logic       cfg_start;
    logic       cfg_bit_valid;
    logic       cfg_bit;
    logic       f4, ov4, busy4, done4;
    logic       f2, ov2, busy2, done2;

    always #5 clk = ~clk;

    lut_function_unit #(.N_IN(4)) u_dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_vec        (in_vec4),
        .f             (f4),
        .out_valid     (ov4),
        .cfg_start     (cfg_start),
        .cfg_bit_valid (cfg_bit_valid),
        .cfg_bit       (cfg_bit),
        .cfg_busy      (busy4),
        .cfg_done      (done4)
    );

    lut_function_unit #(.N_IN(2), .INIT_TABLE(4'b0110)) u_dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_vec        (in_vec2),
        .f             (f2),
        .out_valid     (ov2),
        .cfg_start     (cfg_start),
        .cfg_bit_valid (cfg_bit_valid),
        .cfg_bit       (cfg_bit),
        .cfg_busy      (busy2),
        .cfg_done      (done2)
    );

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    int fix_vec = -1;

    // Behavioural model, index 0 = 4-input unit, index 1 = 2-input unit.
    int m_w[2]    = '{16, 4};
    int m_init[2] = '{32'h28AC, 32'h6};
    int m_table[2];
    int m_acc[2];
    int m_cnt[2];
    bit m_load[2];
    bit m_pend[2];
    bit m_f[2];
    bit m_ov[2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_table[k] = m_init[k];
            m_acc[k]   = 0;
            m_cnt[k]   = 0;
            m_load[k]  = 1'b0;
            m_pend[k]  = 1'b0;
            m_f[k]     = 1'b0;
            m_ov[k]    = 1'b0;
        end
    endfunction

    function automatic void model_step();
        int v;
        for (int k = 0; k < 2; k++) begin
            v = (k == 0) ? int'(in_vec4) : int'(in_vec2);
            if (in_valid) begin
                m_f[k]  = ((m_table[k] >> v) & 1) != 0;
                m_ov[k] = 1'b1;
            end else begin
                m_ov[k] = 1'b0;
            end
            if (m_pend[k]) begin
                m_table[k] = m_acc[k];
                m_pend[k]  = 1'b0;
            end else if (m_load[k]) begin
                if (cfg_start) begin
                    m_cnt[k] = 0;
                    m_acc[k] = 0;
                end else if (cfg_bit_valid) begin
                    // First bit received is the highest minterm.
                    if (cfg_bit) m_acc[k] = m_acc[k] + (1 << (m_w[k] - 1 - m_cnt[k]));
                    m_cnt[k]++;
                    if (m_cnt[k] == m_w[k]) begin
                        m_load[k] = 1'b0;
                        m_pend[k] = 1'b1;
                    end
                end
            end else if (cfg_start) begin
                m_load[k] = 1'b1;
                m_cnt[k]  = 0;
                m_acc[k]  = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed=%0h expected=%0h", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("u4.f",         32'(f4),    32'(m_f[0]));
        chk("u4.out_valid", 32'(ov4),   32'(m_ov[0]));
        chk("u4.cfg_busy",  32'(busy4), 32'(m_load[0]));
        chk("u4.cfg_done",  32'(done4), 32'(m_pend[0]));
        chk("u2.f",         32'(f2),    32'(m_f[1]));
        chk("u2.out_valid", 32'(ov2),   32'(m_ov[1]));
        chk("u2.cfg_busy",  32'(busy2), 32'(m_load[1]));
        chk("u2.cfg_done",  32'(done2), 32'(m_pend[1]));
    endtask

    task automatic cyc();
        if (!rst_n) model_reset();
        else        model_step();
        @(posedge clk);
        #1;
        cyc_no++;
        check_outputs();
    endtask

    task automatic rand_eval();
        in_valid = ($urandom_range(0, 3) != 0);
        if (fix_vec >= 0) begin
            in_valid = 1'b1;
            in_vec4  = fix_vec[3:0];
        end else begin
            in_vec4 = 4'($urandom_range(0, 15));
        end
        in_vec2 = 2'($urandom_range(0, 3));
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        rand_eval();
        cyc();
        cfg_start = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] val, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                cfg_bit_valid = 1'b0;
                rand_eval();
                cyc();
            end
            cfg_bit_valid = 1'b1;
            cfg_bit       = val[15-i];
            rand_eval();
            cyc();
        end
        cfg_bit_valid = 1'b0;
    endtask

    task automatic sweep();
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_vec4 = 4'(i);
            in_vec2 = 2'(i);
            cyc();
        end
    endtask

    initial begin
        logic [15:0] rnd;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_vec4       = '0;
        in_vec2       = '0;
        cfg_start     = 1'b0;
        cfg_bit_valid = 1'b0;
        cfg_bit       = 1'b0;
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;

        // Default tables: primes on the 4-input unit, XOR on the 2-input unit.
        sweep();
        in_valid = 1'b0;
        cyc();
        cyc();

        // 8001 on the 4-input unit; its first four bits give AND on the 2-input unit.
        start_load();
        send_bits(16'h8001, 16, 1'b0);
        cyc();
        sweep();

        // Table swap while continuously evaluating minterm 3.
        start_load();
        send_bits(16'h0008, 16, 1'b0);
        fix_vec = 3;
        start_load();
        send_bits(16'h0000, 16, 1'b0);
        cyc();
        cyc();
        fix_vec = -1;

        // Restart after 7 bits with a coincident bit that must be dropped.
        start_load();
        rnd = 16'($urandom);
        send_bits(rnd, 7, 1'b0);
        cfg_start     = 1'b1;
        cfg_bit_valid = 1'b1;
        cfg_bit       = 1'b0;
        rand_eval();
        cyc();
        cfg_start     = 1'b0;
        send_bits(16'hFFFF, 16, 1'b0);
        // cfg_start held through the commit cycle is taken from IDLE afterwards.
        cfg_start = 1'b1;
        rand_eval();
        cyc();
        rand_eval();
        cyc();
        cfg_start = 1'b0;
        send_bits(16'h28AC, 16, 1'b0);
        cyc();
        sweep();

        // Randomized tables with gaps between bits.
        for (int n = 0; n < 4; n++) begin
            start_load();
            rnd = 16'($urandom);
            send_bits(rnd, 16, 1'b1);
            for (int j = 0; j < 4; j++) begin
                rand_eval();
                cyc();
            end
            sweep();
        end

        // Asynchronous reset in the middle of a load.
        start_load();
        send_bits(16'h0000, 10, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        in_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        sweep();
        in_valid = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lut_function_unit.md
Name: lut_function_unit

Overview:
- Parametrised, run-time programmable N-input Boolean function unit.
- Evaluates f(in_vec) as a sum of minterms held in a 2^N_IN-bit truth table.
- The truth table is loaded serially through a handshaked configuration port.
- Output is registered with valid tracking. Sits in the lab datapath wherever a fixed minterm function was hard-wired, so the function can be swapped without resynthesis.

Parameters:
- N_IN, 4, number of function inputs (1..6); TABLE_W = 2^N_IN.
- INIT_TABLE, 16'h28AC (width TABLE_W), reset truth table; bit k = f for minterm k. Default = minterms 2,3,5,7,11,13.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  evaluation request this cycle.
- in_vec  in  N_IN  function inputs; MSB = first variable (a), LSB = last (d for N_IN=4); minterm index = unsigned in_vec.
- f  out  1  registered function result.
- out_valid  out  1  f corresponds to an accepted request.
- cfg_start  in  1  begin (or restart) a table load.
- cfg_bit_valid  in  1  cfg_bit is presented.
- cfg_bit  in  1  serial table bit, MSB (minterm TABLE_W-1) first.
- cfg_busy  out  1  loader in LOAD state.
- cfg_done  out  1  one-cycle pulse: new table committed.

Behaviour:
- Reset (async assert, sync release): active table = INIT_TABLE, shadow = 0, count = 0, state IDLE; f = 0, out_valid = 0, cfg_busy = 0, cfg_done = 0.
- Evaluation:
  - 1-cycle latency. On the rising edge with in_valid=1: f <= table[in_vec], out_valid <= 1.
  - With in_valid=0: out_valid <= 0 and f holds its last value.
  - Full throughput, one result per cycle, no backpressure.
- Loader FSM, states IDLE, LOAD, COMMIT:
  - IDLE: cfg_start -> LOAD; count <= 0, shadow cleared. cfg_bit_valid is ignored in IDLE.
  - LOAD: each cfg_bit_valid shifts cfg_bit into shadow LSB (shadow <= {shadow[TABLE_W-2:0], cfg_bit}) and increments count. When a bit is accepted with count == TABLE_W-1 -> COMMIT. cfg_busy = 1 throughout LOAD.
  - LOAD, restart: cfg_start in LOAD discards partial data, restarts count at 0 and stays in LOAD. If cfg_start and cfg_bit_valid are high in the same cycle, cfg_start wins and the bit is dropped.
  - COMMIT: table <= shadow, cfg_done = 1 for this single cycle, -> IDLE. cfg_start in COMMIT is honoured next cycle from IDLE.
- Table update atomicity: evaluations keep using the old table until the COMMIT edge. A request in the COMMIT cycle uses the old table; the next cycle uses the new one. Partial loads never affect f.
- Counter width is N_IN+1 bits and must not wrap before TABLE_W bits are accepted.
- Reset during LOAD or COMMIT aborts the load; the table reverts to INIT_TABLE.
- in_vec X/Z is not checked; only the N_IN-bit index is used.

Decomposition:
- Shared package lut_pkg:
  - loader state enum (IDLE, LOAD, COMMIT);
  - function for TABLE_W from N_IN;
  - constant for the default 4-input table 16'h28AC.
- One sub-module, lut_cfg_loader: FSM, shift register, counter, cfg_busy/cfg_done. It outputs the shadow table and a commit strobe.
- The top level holds the active table register and the output register.

Test Plan:
- Reset defaults: release rst_n, sweep in_vec 0..15 with in_valid=1 -> f=1 exactly for 2,3,5,7,11,13, each result one cycle later with out_valid=1. Drop in_valid -> out_valid=0 next cycle, f held.
- Full load: cfg_start, then 16 bits of 16'h8001 MSB-first -> cfg_busy high 16 cycles, cfg_done pulse on the commit cycle. Then f=1 only for in_vec 0 and 15.
- Atomicity: evaluate in_vec=3 every cycle during a load of 16'h0000 -> f=1 until the COMMIT cycle's result; f=0 from the following request onward.
- Restart: send 7 bits, then cfg_start with cfg_bit_valid=1, then 16 bits of 16'hFFFF -> the dropped bit is not counted; table = FFFF; one cfg_done only.
- Mid-load reset: send 10 bits of 16'h0000, assert rst_n=0 asynchronously (between edges) -> outputs 0 immediately, cfg_busy=0. Table = 16'h28AC (in_vec=2 -> f=1).
- N_IN=2 instance, INIT_TABLE=4'b0110 -> XOR behaviour. Load 4'b1000 -> AND; cfg_done after exactly 4 accepted bits.
